sipo_deserializer: RTL
======================

Name: sipo_deserializer

Overview:
- Serial-in/parallel-out stage that sits directly upstream of the single-bit D flip-flop registers.
- Collects a qualified serial bit stream into WIDTH-bit words.
- Holds each completed word in a one-entry output buffer with a valid/ready handshake.
- Flags words that are dropped because the buffer is full.

Parameters:
- WIDTH, 8, data bits per word (minimum 2).
- MSB_FIRST, 1, 1 = the first received bit lands in q[WIDTH-1]; 0 = it lands in q[0].

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous active-low reset.
- d  input  1  serial data bit.
- d_valid  input  1  d is sampled on this clock edge when high.
- sync_clr  input  1  synchronous discard of the partially assembled word.
- q  output  WIDTH  buffered parallel word.
- q_valid  output  1  q holds an unconsumed word.
- q_ready  input  1  consumer accepts q this cycle when q_valid is also high.
- overflow  output  1  sticky: a completed word was dropped.
- overflow_clr  input  1  synchronous clear of overflow.
- parity_err  output  1  parity status of the word in q (see Optional Feature).
- bit_cnt  output  $clog2(WIDTH+2)  number of bits of the current word received so far.

Behaviour:
- Reset (rst low, asynchronous): shift register, bit_cnt, q, q_valid, overflow and parity_err all go to 0. The partial word and any buffered word are lost.
- Bit accept: on each edge with d_valid=1 and sync_clr=0, bit_cnt increments.
  - MSB_FIRST=1: shift <= {shift[WIDTH-2:0], d}.
  - MSB_FIRST=0: shift <= {d, shift[WIDTH-1:1]}.
  - d_valid=0: shift register and bit_cnt hold. Arbitrary gaps between bits are allowed.
- Word completion: occurs on the edge that accepts the last bit of a word (bit_cnt = WIDTH-1, or WIDTH with parity enabled).
  - The assembled word, including that last bit, is written to q.
  - q_valid=1 after that edge (latency 1 clock from the last bit).
  - bit_cnt returns to 0.
- Handshake: q_valid && q_ready at an edge consumes the word, and q_valid falls unless a word completes on the same edge.
  - q is stable while q_valid=1 and q_ready=0.
  - q is not cleared on consume; it holds its last value.
- Full buffer: if a word completes while q_valid=1 and q_ready=0:
  - the new word is dropped;
  - q and parity_err keep the old word;
  - overflow is set to 1;
  - bit_cnt still returns to 0.
- Simultaneous consume and complete: the new word loads into q, q_valid stays 1, and no overflow is raised.
- overflow clear: overflow_clr=1 clears overflow on the next edge. If an overflow event occurs on the same edge, set wins and overflow stays 1.
- sync_clr=1: bit_cnt <= 0 and the shift register <= 0. An incoming bit on the same edge is discarded. q, q_valid and overflow are unaffected.
- No state machine beyond the counter. bit_cnt never exceeds the word length minus 1.

Optional Feature:
- Macro: SIPO_PARITY_EN.
- Defined:
  - Each word is WIDTH data bits followed by one even-parity bit; bit_cnt counts 0..WIDTH.
  - The parity bit is not stored in q.
  - On completion, parity_err <= XOR(data bits, parity bit), loaded together with q.
  - parity_err follows the same hold, drop and overflow rules as q.
- Undefined: words are WIDTH bits and parity_err is constant 0.

Test Plan:
- Byte reception, MSB_FIRST=1, WIDTH=8, q_ready=1: bits 1,1,0,0,0,0,0,0 with a 3-cycle d_valid gap after the 4th bit -> q=8'hC0. q_valid is high for exactly 1 cycle, starting 1 clock after the 8th bit. bit_cnt reads 4 during the gap.
- Bit order, MSB_FIRST=0: same bit sequence -> q=8'h03.
- Overflow, q_ready=0: send 8'h3C then 8'h81 -> q stays 8'h3C, q_valid=1, overflow=1. Then pulse overflow_clr -> overflow=0. Pulse overflow_clr on the same edge as a third dropped word -> overflow stays 1.
- Simultaneous consume and complete: word 8'h55 buffered; assert q_ready on the edge the last bit of 8'hAA is accepted -> q=8'hAA, q_valid stays 1, overflow=0.
- Clear and reset: after 3 bits, pulse sync_clr together with d_valid=1, then send 8'hFF -> q=8'hFF, bit_cnt=0. Then drop rst mid-word after 5 bits -> q=0, q_valid=0, bit_cnt=0 immediately without waiting for a clock edge. The next 8 bits form a full word.
- Parity (SIPO_PARITY_EN): data 8'hA5 followed by parity bit 0 -> parity_err=0. Data 8'hA5 followed by parity bit 1 -> parity_err=1, q=8'hA5.

Source files
------------

// File: rtl/sipo_deserializer_if.sv
// rtl/sipo_deserializer_if.sv - serial input / buffered word output bundle for sipo_deserializer
interface sipo_deserializer_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH + 2);

    logic             d;
    logic             d_valid;
    logic             sync_clr;
    logic             q_ready;
    logic             overflow_clr;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic             overflow;
    logic             parity_err;
    logic [CW-1:0]    bit_cnt;

    modport master (
        output d, d_valid, sync_clr, q_ready, overflow_clr,
        input  q, q_valid, overflow, parity_err, bit_cnt
    );

    modport slave (
        input  d, d_valid, sync_clr, q_ready, overflow_clr,
        output q, q_valid, overflow, parity_err, bit_cnt
    );
endinterface

// File: rtl/sipo_deserializer.sv
// rtl/sipo_deserializer.sv - serial-to-parallel word collector with one-entry output buffer
// Optional trailing even-parity bit per word when SIPO_PARITY_EN is defined.
module sipo_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    sipo_deserializer_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 2);
`ifdef SIPO_PARITY_EN
    localparam int LAST = WIDTH;
`else
    localparam int LAST = WIDTH - 1;
`endif

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             q_valid_q, q_valid_d;
    logic             ovf_q, ovf_d;
    logic             accept, complete, consume, load, drop;

    assign shifted  = MSB_FIRST ? {shift_q[WIDTH-2:0], bus.d} : {bus.d, shift_q[WIDTH-1:1]};
    assign accept   = bus.d_valid && !bus.sync_clr;
    assign complete = accept && (cnt_q == CW'(LAST));
    assign consume  = q_valid_q && bus.q_ready;
    // A completing word may take the slot only if it is empty or being drained now.
    assign load     = complete && (!q_valid_q || bus.q_ready);
    assign drop     = complete && q_valid_q && !bus.q_ready;

`ifdef SIPO_PARITY_EN
    logic perr_q, perr_d;
    // The incoming bit at completion is the parity bit; data is already in the shifter.
    assign word = shift_q;
    always_comb begin
        perr_d = perr_q;
        if (load) begin
            perr_d = ^{shift_q, bus.d};
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end
    assign bus.parity_err = perr_q;
`else
    assign word           = shifted;
    assign bus.parity_err = 1'b0;
`endif

    always_comb begin
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        q_d       = q_q;
        q_valid_d = q_valid_q;
        ovf_d     = ovf_q;

        if (bus.sync_clr) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (accept) begin
            if (complete) begin
                cnt_d = '0;
`ifndef SIPO_PARITY_EN
                shift_d = shifted;
`endif
            end else begin
                cnt_d   = cnt_q + CW'(1);
                shift_d = shifted;
            end
        end

        if (load) begin
            q_d       = word;
            q_valid_d = 1'b1;
        end else if (consume) begin
            q_valid_d = 1'b0;
        end

        if (drop) begin
            ovf_d = 1'b1;
        end else if (bus.overflow_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q   <= '0;
            cnt_q     <= '0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.q        = q_q;
    assign bus.q_valid  = q_valid_q;
    assign bus.overflow = ovf_q;
    assign bus.bit_cnt  = cnt_q;
endmodule
